game_ctl: RTL and testbench

- Match sequencer for the Pong datapath. Sits between the debounced buttons, the ball controller and the score display.
- Decides when the ball is recentred, when it may move, and which direction it is served. Owns both score registers and detects match end.
- Replaces free-running ball motion with an IDLE → SERVE → PLAY → OVER flow.

---
 rtl/game_ctl.sv | 154 +++++++++++++++
 tb/tb_game_ctl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctl.sv
// Pong match sequencer: serve timing, score registers and match-end detection.
// Runs the IDLE -> SERVE -> PLAY -> OVER flow that gates the ball controller.
module game_ctl #(
    parameter int WIN_SCORE          = 11,
    parameter int SERVE_DELAY_FRAMES = 60,
    parameter int OVER_HOLD_FRAMES   = 180
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       ball_run,
    output logic       ball_center,
    output logic       serve_dir,
    output logic [6:0] points_first_player,
    output logic [6:0] points_second_player,
    output logic       game_over,
    output logic       winner,
    output logic [1:0] state_o
);

    localparam int MAXF = (SERVE_DELAY_FRAMES > OVER_HOLD_FRAMES) ?
                          SERVE_DELAY_FRAMES : OVER_HOLD_FRAMES;
    localparam int CW   = $clog2(MAXF + 1);

    localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_DELAY_FRAMES - 1);
    localparam logic [CW-1:0] HOLD_MAX   = CW'(OVER_HOLD_FRAMES);
    localparam logic [6:0]    WIN        = 7'(WIN_SCORE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_PLAY  = 2'd2,
        S_OVER  = 2'd3
    } state_e;

    state_e        state_q;
    logic [CW-1:0] frame_q;
    logic          armed_q;
    logic [6:0]    p1_q;
    logic [6:0]    p2_q;
    logic          run_q;
    logic          center_q;
    logic          dir_q;
    logic          over_q;
    logic          winner_q;

    logic          press_d;
    logic [6:0]    p1_d;
    logic [6:0]    p2_d;

    // armed_q means "buttons were released last cycle"; it resets low so a
    // button held through reset must be released before it counts again.
    always_comb begin
        press_d = (btn_up | btn_down) & armed_q;
        p1_d    = p1_q + 7'd1;
        p2_d    = p2_q + 7'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            frame_q  <= '0;
            armed_q  <= 1'b0;
            p1_q     <= 7'd0;
            p2_q     <= 7'd0;
            run_q    <= 1'b0;
            center_q <= 1'b0;
            dir_q    <= 1'b1;
            over_q   <= 1'b0;
            winner_q <= 1'b0;
        end else begin
            armed_q  <= ~(btn_up | btn_down);
            center_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (press_d) begin
                        state_q  <= S_SERVE;
                        frame_q  <= '0;
                        p1_q     <= 7'd0;
                        p2_q     <= 7'd0;
                        dir_q    <= 1'b1;
                        center_q <= 1'b1;
                    end
                end
                S_SERVE: begin
                    if (frame_tick) begin
                        if (frame_q == SERVE_LAST) begin
                            state_q <= S_PLAY;
                            frame_q <= '0;
                            run_q   <= 1'b1;
                        end else begin
                            frame_q <= frame_q + 1'b1;
                        end
                    end
                end
                S_PLAY: begin
                    if (miss_left || miss_right) begin
                        run_q   <= 1'b0;
                        frame_q <= '0;
                        // miss_left takes priority when both arrive together
                        if (miss_left) begin
                            p2_q  <= p2_d;
                            dir_q <= 1'b0;
                            if (p2_d == WIN) begin
                                state_q  <= S_OVER;
                                over_q   <= 1'b1;
                                winner_q <= 1'b1;
                            end else begin
                                state_q  <= S_SERVE;
                                center_q <= 1'b1;
                            end
                        end else begin
                            p1_q  <= p1_d;
                            dir_q <= 1'b1;
                            if (p1_d == WIN) begin
                                state_q  <= S_OVER;
                                over_q   <= 1'b1;
                                winner_q <= 1'b0;
                            end else begin
                                state_q  <= S_SERVE;
                                center_q <= 1'b1;
                            end
                        end
                    end
                end
                S_OVER: begin
                    if (frame_q == HOLD_MAX) begin
                        if (press_d) begin
                            state_q <= S_IDLE;
                            frame_q <= '0;
                            over_q  <= 1'b0;
                        end
                    end else if (frame_tick) begin
                        frame_q <= frame_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign ball_run             = run_q;
    assign ball_center          = center_q;
    assign serve_dir            = dir_q;
    assign points_first_player  = p1_q;
    assign points_second_player = p2_q;
    assign game_over            = over_q;
    assign winner               = winner_q;
    assign state_o              = state_q;

endmodule

// File: tb/tb_game_ctl.sv
// Testbench for game_ctl: directed scenarios plus a random run,
// each checked against a cycle-level reference model of the match rules.
module tb_game_ctl;

    localparam int WIN = 11;
    localparam int SD  = 60;
    localparam int OH  = 180;

    logic       clk = 1'b0;
    logic       rst;
    logic       ft, bu, bd, ml, mr;
    logic       ball_run, ball_center, serve_dir, game_over, winner;
    logic [6:0] p1, p2;
    logic [1:0] state_o;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [20:0] RST_V = {2'd0, 1'b0, 1'b0, 1'b1,
                                     7'd0, 7'd0, 1'b0, 1'b0};

    game_ctl #(
        .WIN_SCORE          (WIN),
        .SERVE_DELAY_FRAMES (SD),
        .OVER_HOLD_FRAMES   (OH)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .frame_tick           (ft),
        .btn_up               (bu),
        .btn_down             (bd),
        .miss_left            (ml),
        .miss_right           (mr),
        .ball_run             (ball_run),
        .ball_center          (ball_center),
        .serve_dir            (serve_dir),
        .points_first_player  (p1),
        .points_second_player (p2),
        .game_over            (game_over),
        .winner               (winner),
        .state_o              (state_o)
    );

    always #5 clk = ~clk;

    logic [20:0] dut_v;
    assign dut_v = {state_o, ball_run, ball_center, serve_dir,
                    p1, p2, game_over, winner};

    // Reference model: mode 0..3, tick count since entering the mode
    int m_mode, m_p1, m_p2, m_ticks;
    bit m_run, m_center, m_dir, m_over, m_win, m_released;

    task automatic m_reset();
        m_mode = 0; m_p1 = 0; m_p2 = 0; m_ticks = 0;
        m_run = 0; m_center = 0; m_dir = 1;
        m_over = 0; m_win = 0; m_released = 0;
    endtask

    task automatic m_update(input bit f, u, d, l, r);
        bit press;
        press = (u || d) && m_released;
        m_released = !(u || d);
        m_center = 0;
        case (m_mode)
            0: if (press) begin
                m_mode = 1; m_ticks = 0;
                m_p1 = 0; m_p2 = 0; m_dir = 1; m_center = 1;
            end
            1: if (f) begin
                m_ticks++;
                if (m_ticks == SD) begin
                    m_mode = 2; m_ticks = 0; m_run = 1;
                end
            end
            2: if (l || r) begin
                m_run = 0; m_ticks = 0;
                if (l) begin m_p2++; m_dir = 0; end
                else   begin m_p1++; m_dir = 1; end
                if (m_p1 == WIN || m_p2 == WIN) begin
                    m_mode = 3; m_over = 1; m_win = (m_p2 == WIN);
                end else begin
                    m_mode = 1; m_center = 1;
                end
            end
            default: begin
                if (press && m_ticks >= OH) begin
                    m_mode = 0; m_over = 0; m_ticks = 0;
                end else if (f && m_ticks < OH) begin
                    m_ticks++;
                end
            end
        endcase
    endtask

    function automatic logic [20:0] exp_v();
        return {2'(m_mode), m_run, m_center, m_dir,
                7'(m_p1), 7'(m_p2), m_over, m_win};
    endfunction

    task automatic step(input bit f, u, d, l, r);
        ft = f; bu = u; bd = d; ml = l; mr = r;
        @(posedge clk);
        if (rst) m_reset();
        else     m_update(f, u, d, l, r);
        #1;
    endtask

    task automatic serve_wait();
        for (int i = 0; i < 2000 && m_mode == 1; i++)
            step($urandom_range(0, 3) != 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1;
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 1);
        n_chk++;
        if (dut_v !== RST_V) begin
            n_fail++;
            $display("FAIL reset_vals got=%h exp=%h", dut_v, RST_V);
        end
        rst = 0;
        step(0, 0, 0, 0, 0);
        n_chk++;
        if (dut_v !== exp_v()) begin
            n_fail++;
            $display("FAIL reset_release got=%h exp=%h", dut_v, exp_v());
        end
    endtask

    task automatic test_serve_start();
        int ticks;
        bit f;
        step(0, 1, 0, 0, 0);
        n_chk++;
        if (state_o !== 2'd1 || ball_center !== 1'b1 || p1 !== 0 || p2 !== 0) begin
            n_fail++;
            $display("FAIL press_start got st=%0d c=%b s=%0d:%0d exp st=1 c=1 s=0:0",
                     state_o, ball_center, p1, p2);
        end
        step(0, 0, 0, 0, 0);
        n_chk++;
        if (ball_center !== 1'b0 || dut_v !== exp_v()) begin
            n_fail++;
            $display("FAIL center_pulse got=%h exp=%h", dut_v, exp_v());
        end
        ticks = 0;
        for (int i = 0; i < 1000 && ticks < SD; i++) begin
            f = ($urandom_range(0, 3) != 0);
            step(f, 0, 0, 0, 0);
            if (f) ticks++;
            n_chk++;
            if (dut_v !== exp_v()) begin
                n_fail++;
                $display("FAIL serve_count t=%0d got=%h exp=%h", ticks, dut_v, exp_v());
            end
        end
        n_chk++;
        if (state_o !== 2'd2 || ball_run !== 1'b1) begin
            n_fail++;
            $display("FAIL serve_done got st=%0d run=%b exp st=2 run=1",
                     state_o, ball_run);
        end
    endtask

    task automatic test_miss();
        step(0, 0, 0, 0, 1);
        n_chk++;
        if (p1 !== 7'd1 || serve_dir !== 1'b1 || state_o !== 2'd1 ||
            ball_center !== 1'b1 || ball_run !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_right got=%h exp p1=1 dir=1 st=1 c=1 run=0", dut_v);
        end
        serve_wait();
        step(0, 0, 0, 1, 0);
        n_chk++;
        if (p2 !== 7'd1 || p1 !== 7'd1 || serve_dir !== 1'b0 ||
            state_o !== 2'd1 || ball_center !== 1'b1 || ball_run !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_left got=%h exp p1=1 p2=1 dir=0 st=1", dut_v);
        end
    endtask

    task automatic test_win();
        bit u, f;
        serve_wait();
        for (int i = 0; i < 20 && m_p2 < WIN - 1; i++) begin
            step(0, 0, 0, 1, 0);
            serve_wait();
        end
        n_chk++;
        if (p2 !== 7'(WIN - 1) || state_o !== 2'd2) begin
            n_fail++;
            $display("FAIL pre_win got p2=%0d st=%0d exp p2=10 st=2", p2, state_o);
        end
        step(0, 0, 0, 1, 0);
        n_chk++;
        if (p2 !== 7'd11 || state_o !== 2'd3 || game_over !== 1'b1 ||
            winner !== 1'b1 || ball_run !== 1'b0) begin
            n_fail++;
            $display("FAIL win got=%h exp p2=11 st=3 over=1 win=1", dut_v);
        end
        for (int i = 0; i < 3000 && m_ticks < OH; i++) begin
            u = $urandom_range(0, 1);
            f = $urandom_range(0, 1);
            step(f, u, 0, 0, 0);
            n_chk++;
            if (state_o !== 2'd3 || dut_v !== exp_v()) begin
                n_fail++;
                $display("FAIL over_hold got=%h exp=%h", dut_v, exp_v());
            end
        end
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        n_chk++;
        if (state_o !== 2'd0 || p2 !== 7'd11 || game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL over_exit got st=%0d p2=%0d over=%b exp st=0 p2=11 over=0",
                     state_o, p2, game_over);
        end
    endtask

    task automatic test_simul();
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        serve_wait();
        step(0, 0, 0, 1, 1);
        n_chk++;
        if (p1 !== 7'd0 || p2 !== 7'd1 || serve_dir !== 1'b0 || state_o !== 2'd1) begin
            n_fail++;
            $display("FAIL simul_miss got p1=%0d p2=%0d dir=%b exp p1=0 p2=1 dir=0",
                     p1, p2, serve_dir);
        end
    endtask

    task automatic test_ignored();
        for (int i = 0; i < 10; i++)
            step($urandom_range(0, 1), 0, 0, $urandom_range(0, 1), 1);
        n_chk++;
        if (p1 !== 7'd0 || p2 !== 7'd1 || state_o !== 2'd1) begin
            n_fail++;
            $display("FAIL serve_miss got p1=%0d p2=%0d st=%0d exp 0 1 1",
                     p1, p2, state_o);
        end
        rst = 1;
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        rst = 0;
        for (int i = 0; i < 5; i++)
            step(0, 1, 0, 1, i[0]);
        n_chk++;
        if (state_o !== 2'd0 || p1 !== 7'd0 || p2 !== 7'd0) begin
            n_fail++;
            $display("FAIL held_btn got st=%0d s=%0d:%0d exp st=0 s=0:0",
                     state_o, p1, p2);
        end
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        n_chk++;
        if (state_o !== 2'd1 || ball_center !== 1'b1) begin
            n_fail++;
            $display("FAIL repress got st=%0d c=%b exp st=1 c=1", state_o, ball_center);
        end
    endtask

    task automatic test_reset_mid_serve();
        int nl, nr;
        bit left;
        serve_wait();
        nl = 0;
        nr = 0;
        while (nl < 5 || nr < 3) begin
            left = (nr >= 3) || (nl < 5 && $urandom_range(0, 1) == 1);
            if (left) nl++; else nr++;
            step(0, 0, 0, left, !left);
            if (nl < 5 || nr < 3) serve_wait();
        end
        for (int i = 0; i < 1000 && m_ticks < 30; i++)
            step($urandom_range(0, 1), 0, 0, 0, 0);
        n_chk++;
        if (p1 !== 7'd3 || p2 !== 7'd5 || state_o !== 2'd1) begin
            n_fail++;
            $display("FAIL pre_reset got s=%0d:%0d st=%0d exp 3:5 st=1", p1, p2, state_o);
        end
        #2;
        rst = 1;
        #1;
        m_reset();
        n_chk++;
        if (dut_v !== RST_V) begin
            n_fail++;
            $display("FAIL async_reset got=%h exp=%h", dut_v, RST_V);
        end
        step(0, 0, 0, 0, 0);
        rst = 0;
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < SD - 1; i++)
            step(1, 0, 0, 0, 0);
        n_chk++;
        if (state_o !== 2'd1 || ball_run !== 1'b0) begin
            n_fail++;
            $display("FAIL serve_59 got st=%0d run=%b exp st=1 run=0", state_o, ball_run);
        end
        step(1, 0, 0, 0, 0);
        n_chk++;
        if (state_o !== 2'd2 || ball_run !== 1'b1) begin
            n_fail++;
            $display("FAIL serve_60 got st=%0d run=%b exp st=2 run=1", state_o, ball_run);
        end
    endtask

    task automatic test_random();
        bit u;
        u = 0;
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 1499) == 0);
            if ($urandom_range(0, 7) == 0) u = !u;
            step($urandom_range(0, 1), u, 0,
                 $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0);
            n_chk++;
            if (dut_v !== exp_v()) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_v, exp_v());
            end
        end
        rst = 0;
    endtask

    initial begin
        rst = 1; ft = 0; bu = 0; bd = 0; ml = 0; mr = 0;
        m_reset();
        test_reset();
        test_serve_start();
        test_miss();
        test_win();
        test_simul();
        test_ignored();
        test_reset_mid_serve();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
